rr_arb_requester: RTL

- Requester-side companion to the 4-way round-robin arbiter: the block that drives req and consumes grant.
- Each channel queues jobs, raises req, and counts BURST_LEN granted beats per job.
- After each job it drops req for one cycle so the arbiter can rotate.
- Flags starvation (no grant within TIMEOUT cycles) and protocol violations on grant.
- Sits between N client engines and the arbiter's req/grant pins.

---
 rtl/rr_arb_requester.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/rr_arb_requester.sv
// rr_arb_requester: requester-side front end for a round-robin arbiter.
// Each channel keeps a count of queued jobs. It raises req and counts
// BURST_LEN granted beats per job. After each job it drops req for one
// cycle so the arbiter can rotate. It also flags starvation and illegal
// grant patterns.
//
// Per-channel FSM:
//   state      | meaning
//   -----------+-----------------------------------------------------------
//   ST_IDLE    | no pending work, req low
//   ST_REQ     | job pending, req high, waiting for the first beat
//   ST_XFER    | burst in progress, req high, counting granted beats
//   ST_RELEASE | job finished, req low for one cycle so the arbiter rotates
module rr_arb_requester #(
    parameter int N         = 4,
    parameter int BURST_LEN = 4,
    parameter int CNT_W     = 4,
    parameter int TIMEOUT   = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] job_push,
    input  logic [N-1:0] grant,
    output logic [N-1:0] req,
    output logic [N-1:0] beat,
    output logic [N-1:0] done,
    output logic [N-1:0] pend_full,
    output logic [N-1:0] starve,
    output logic         proto_err
);

    // beat_cnt only ever holds 0..BURST_LEN-1, because it clears on the last beat.
    localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0]  PEND_MAX  = '1;
    localparam logic [CNT_W-1:0]  PEND_ONE  = CNT_W'(1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_ONE  = BEAT_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [N-1:0]      GRANT_ONE = N'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_XFER    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    logic grant_multi;
    logic grant_stray;

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t             state;
        state_t             state_nxt;
        logic [CNT_W-1:0]   pend_cnt;
        logic [CNT_W-1:0]   pend_nxt;
        logic [BEAT_W-1:0]  beat_cnt;
        logic [BEAT_W-1:0]  beat_nxt;
        logic [WAIT_W-1:0]  wait_cnt;
        logic [WAIT_W-1:0]  wait_nxt;
        logic               req_ch;
        logic               beat_ch;
        logic               full_ch;
        logic               push_ok;
        logic               job_done;
        logic               done_q;
        logic               starve_q;

        assign req_ch  = (state == ST_REQ) || (state == ST_XFER);
        // A beat needs our own req, so a stray grant can never advance a burst.
        assign beat_ch = req_ch & grant[i];
        assign full_ch = (pend_cnt == PEND_MAX);
        assign push_ok = job_push[i] & ~full_ch;

        // Next-state, burst progress and job-completion decode.
        always_comb begin
            state_nxt = state;
            beat_nxt  = beat_cnt;
            job_done  = 1'b0;
            case (state)
                ST_IDLE: begin
                    if ((pend_cnt != '0) || job_push[i]) begin
                        state_nxt = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (grant[i]) begin
                        if (BURST_LEN == 1) begin
                            job_done  = 1'b1;
                            beat_nxt  = '0;
                            state_nxt = ST_RELEASE;
                        end else begin
                            beat_nxt  = BEAT_ONE;
                            state_nxt = ST_XFER;
                        end
                    end
                end
                ST_XFER: begin
                    if (grant[i]) begin
                        if (beat_cnt == LAST_BEAT) begin
                            job_done  = 1'b1;
                            beat_nxt  = '0;
                            state_nxt = ST_RELEASE;
                        end else begin
                            beat_nxt = beat_cnt + BEAT_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    // pend_cnt already reflects the completed job here.
                    if ((pend_cnt != '0) || job_push[i]) begin
                        state_nxt = ST_REQ;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Pending-job count: a push and a completion in the same cycle cancel out.
        always_comb begin
            pend_nxt = pend_cnt;
            if (push_ok && !job_done) begin
                pend_nxt = pend_cnt + PEND_ONE;
            end else if (!push_ok && job_done) begin
                pend_nxt = pend_cnt - PEND_ONE;
            end
        end

        // Wait counter: counts cycles where req is up but no grant arrives. It saturates at TIMEOUT.
        always_comb begin
            wait_nxt = wait_cnt;
            if ((state == ST_IDLE) || (state == ST_RELEASE) || beat_ch) begin
                wait_nxt = '0;
            end else if (req_ch && !grant[i] && (wait_cnt != WAIT_MAX)) begin
                wait_nxt = wait_cnt + WAIT_ONE;
            end
        end

        // Channel state registers; done is the registered completion strobe.
        always_ff @(posedge clk) begin
            if (reset) begin
                state    <= ST_IDLE;
                pend_cnt <= '0;
                beat_cnt <= '0;
                wait_cnt <= '0;
                done_q   <= 1'b0;
                starve_q <= 1'b0;
            end else begin
                state    <= state_nxt;
                pend_cnt <= pend_nxt;
                beat_cnt <= beat_nxt;
                wait_cnt <= wait_nxt;
                done_q   <= job_done;
                starve_q <= starve_q | (wait_nxt == WAIT_MAX);
            end
        end

        assign req[i]       = req_ch;
        assign beat[i]      = beat_ch;
        assign done[i]      = done_q;
        assign pend_full[i] = full_ch;
        assign starve[i]    = starve_q;
    end

    // Grant checks: more than one bit set, or a grant on a channel that is not requesting.
    always_comb begin
        grant_multi = |(grant & (grant - GRANT_ONE));
        grant_stray = |(grant & ~req);
    end

    // proto_err is sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            proto_err <= 1'b0;
        end else begin
            proto_err <= proto_err | grant_multi | grant_stray;
        end
    end

endmodule
